// File: rtl/host_rom_loader.sv
// host_rom_loader: takes HOST_WIDTH-bit words from the host over a req/ack
// handshake and unpacks each one into bytes. The bytes are written one at a
// time into external SRAM, starting at BASE_ADDR. Each write uses a setup
// cycle, then a WR_PULSE-cycle low write-enable, then a hold cycle. When
// LOAD_BYTES bytes have been committed, host_rom_initialised is raised.
// A host_reset pulse restarts the whole load from the first word.
module host_rom_loader #(
    parameter int ADDR_WIDTH = 21,
    parameter int HOST_WIDTH = 32,
    parameter int BASE_ADDR  = 0,
    parameter int LOAD_BYTES = 131072,
    parameter int WR_PULSE   = 2,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  host_reset,
    input  logic [HOST_WIDTH-1:0] host_bootdata,
    input  logic                  host_bootdata_ack,
    output logic                  host_bootdata_req,
    output logic [ADDR_WIDTH-1:0] romwrite_addr,
    output logic [7:0]            romwrite_data,
    output logic                  romwrite_we_n,
    output logic                  host_rom_initialised,
    output logic [ADDR_WIDTH-1:0] bytes_loaded
);

    localparam int BPW      = HOST_WIDTH / 8;
    localparam int IDX_W    = $clog2(BPW + 1);
    // One extra bit so that a full 2^ADDR_WIDTH load can still be compared.
    localparam int CNT_W    = ADDR_WIDTH + 1;
    localparam int LEAD_LSB = (MSB_FIRST != 0) ? (HOST_WIDTH - 8) : 0;

    localparam logic [IDX_W-1:0]      BPW_C        = IDX_W'(BPW);
    localparam logic [CNT_W-1:0]      LOAD_C       = CNT_W'(LOAD_BYTES);
    localparam logic [ADDR_WIDTH-1:0] BASE_C       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [3:0]            PULSE_LAST_C = 4'(WR_PULSE - 1);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_WAIT_WORD = 3'd1,
        ST_SETUP     = 3'd2,
        ST_PULSE     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t                  state_q,   state_d;
    logic                    ack_dly_q, ack_dly_d;
    logic [HOST_WIDTH-1:0]   shift_q,   shift_d;
    logic [IDX_W-1:0]        idx_q,     idx_d;
    logic [3:0]              pcnt_q,    pcnt_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic                    req_q,     req_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [7:0]              data_q,    data_d;
    logic                    we_n_q,    we_n_d;
    logic                    init_q,    init_d;

    logic                    ack_rise_s;
    logic [HOST_WIDTH-1:0]   shift_next_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic [IDX_W-1:0]        idx_inc_s;

    assign ack_rise_s = host_bootdata_ack & ~ack_dly_q;
    assign cnt_inc_s  = cnt_q + CNT_W'(1);
    assign idx_inc_s  = idx_q + IDX_W'(1);

    // Shift register contents once the byte currently on the bus is consumed.
    always_comb begin
        shift_next_s = shift_q;
        if (MSB_FIRST != 0) begin
            shift_next_s = shift_q << 4'd8;
        end else begin
            shift_next_s = shift_q >> 4'd8;
        end
    end

    // Next-state and registered-output computation; host_reset overrides everything.
    always_comb begin
        state_d   = state_q;
        ack_dly_d = host_bootdata_ack;
        shift_d   = shift_q;
        idx_d     = idx_q;
        pcnt_d    = pcnt_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_n_d    = we_n_q;
        init_d    = init_q;

        if (host_reset) begin
            // Any pulse in flight is cut short; the host resends from word 0.
            state_d = ST_START;
            idx_d   = {IDX_W{1'b0}};
            pcnt_d  = 4'd0;
            cnt_d   = {CNT_W{1'b0}};
            req_d   = 1'b0;
            addr_d  = BASE_C;
            data_d  = 8'h00;
            we_n_d  = 1'b1;
            init_d  = 1'b0;
        end else begin
            case (state_q)
                ST_START: begin
                    state_d = ST_WAIT_WORD;
                    req_d   = 1'b1;
                    we_n_d  = 1'b1;
                    init_d  = 1'b0;
                end
                ST_WAIT_WORD: begin
                    req_d = 1'b1;
                    if (ack_rise_s) begin
                        // The word is captured here and only here.
                        shift_d = host_bootdata;
                        data_d  = host_bootdata[LEAD_LSB +: 8];
                        idx_d   = {IDX_W{1'b0}};
                        req_d   = 1'b0;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_WAIT_WORD;
                    end
                end
                ST_SETUP: begin
                    // Data is already on the bus; open the write strobe next.
                    we_n_d  = 1'b0;
                    pcnt_d  = 4'd0;
                    state_d = ST_PULSE;
                end
                ST_PULSE: begin
                    if (pcnt_q == PULSE_LAST_C) begin
                        we_n_d  = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        we_n_d = 1'b0;
                        pcnt_d = pcnt_q + 4'd1;
                    end
                end
                ST_HOLD: begin
                    we_n_d  = 1'b1;
                    cnt_d   = cnt_inc_s;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    shift_d = shift_next_s;
                    idx_d   = idx_inc_s;
                    if (cnt_inc_s == LOAD_C) begin
                        // Leftover bytes of a final partial word are dropped.
                        state_d = ST_DONE;
                        init_d  = 1'b1;
                        req_d   = 1'b0;
                    end else if (idx_inc_s == BPW_C) begin
                        state_d = ST_WAIT_WORD;
                        req_d   = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        data_d  = shift_next_s[LEAD_LSB +: 8];
                    end
                end
                ST_DONE: begin
                    init_d = 1'b1;
                    req_d  = 1'b0;
                    we_n_d = 1'b1;
                end
                default: begin
                    state_d = ST_START;
                    req_d   = 1'b0;
                    we_n_d  = 1'b1;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_START;
            ack_dly_q <= 1'b0;
            shift_q   <= {HOST_WIDTH{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            pcnt_q    <= 4'd0;
            cnt_q     <= {CNT_W{1'b0}};
            req_q     <= 1'b0;
            addr_q    <= BASE_C;
            data_q    <= 8'h00;
            we_n_q    <= 1'b1;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_dly_q <= ack_dly_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            pcnt_q    <= pcnt_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_n_q    <= we_n_d;
            init_q    <= init_d;
        end
    end

    assign host_bootdata_req    = req_q;
    assign romwrite_addr        = addr_q;
    assign romwrite_data        = data_q;
    assign romwrite_we_n        = we_n_q;
    assign host_rom_initialised = init_q;
    assign bytes_loaded         = cnt_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_host_rom_loader.sv
// Testbench for host_rom_loader. Three instances are built with different
// configurations: A is MSB-first with 8 bytes, B is LSB-first with 4 bytes,
// and C starts at a high base address with a partial final word and a
// one-cycle pulse. A negedge monitor turns the SRAM bus activity into write
// records, and each test compares those records with a byte-stream model.
module tb_host_rom_loader;

    localparam int AW    = 21;
    localparam int HW    = 32;
    localparam int LB_A  = 8;
    localparam int LB_B  = 4;
    localparam int LB_C  = 6;
    localparam int WP_A  = 2;
    localparam int WP_B  = 2;
    localparam int WP_C  = 1;
    localparam int BASEC = 32'h1FFFE;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          host_reset_s [3];
    logic          ack_s [3];
    logic [HW-1:0] word_s [3];
    logic          req_w [3];
    logic [AW-1:0] addr_w [3];
    logic [7:0]    wdata_w [3];
    logic          we_n_w [3];
    logic          init_w [3];
    logic [AW-1:0] bytes_w [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base_of [3] = '{0, 0, BASEC};

    host_rom_loader #(.ADDR_WIDTH(AW), .HOST_WIDTH(HW), .BASE_ADDR(0), .LOAD_BYTES(LB_A),
                      .WR_PULSE(WP_A), .MSB_FIRST(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .host_reset(host_reset_s[0]), .host_bootdata(word_s[0]),
        .host_bootdata_ack(ack_s[0]), .host_bootdata_req(req_w[0]), .romwrite_addr(addr_w[0]),
        .romwrite_data(wdata_w[0]), .romwrite_we_n(we_n_w[0]),
        .host_rom_initialised(init_w[0]), .bytes_loaded(bytes_w[0]));

    host_rom_loader #(.ADDR_WIDTH(AW), .HOST_WIDTH(HW), .BASE_ADDR(0), .LOAD_BYTES(LB_B),
                      .WR_PULSE(WP_B), .MSB_FIRST(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .host_reset(host_reset_s[1]), .host_bootdata(word_s[1]),
        .host_bootdata_ack(ack_s[1]), .host_bootdata_req(req_w[1]), .romwrite_addr(addr_w[1]),
        .romwrite_data(wdata_w[1]), .romwrite_we_n(we_n_w[1]),
        .host_rom_initialised(init_w[1]), .bytes_loaded(bytes_w[1]));

    host_rom_loader #(.ADDR_WIDTH(AW), .HOST_WIDTH(HW), .BASE_ADDR(BASEC), .LOAD_BYTES(LB_C),
                      .WR_PULSE(WP_C), .MSB_FIRST(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .host_reset(host_reset_s[2]), .host_bootdata(word_s[2]),
        .host_bootdata_ack(ack_s[2]), .host_bootdata_req(req_w[2]), .romwrite_addr(addr_w[2]),
        .romwrite_data(wdata_w[2]), .romwrite_we_n(we_n_w[2]),
        .host_rom_initialised(init_w[2]), .bytes_loaded(bytes_w[2]));

    always #5 clk = ~clk;

    // Cycle counter used to timestamp monitor events.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            len;
        bit            stable;
        int            start_c;
        int            end_c;
    } wr_t;

    wr_t           mon_q [$];
    logic          prev_we [3]   = '{1'b1, 1'b1, 1'b1};
    logic          prev_req [3]  = '{1'b0, 1'b0, 1'b0};
    logic          prev_init [3] = '{1'b0, 1'b0, 1'b0};
    int            cur_len [3];
    logic [AW-1:0] cur_addr [3];
    logic [7:0]    cur_data [3];
    bit            cur_stable [3];
    int            cur_start [3];
    int            req_rise_cyc [3];
    int            req_rises [3]  = '{0, 0, 0};
    int            init_rise_cyc [3];

    // Bus monitor: one record per completed we_n low pulse, plus req/init rise times.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!we_n_w[d] && prev_we[d]) begin
                cur_len[d]    <= 1;
                cur_addr[d]   <= addr_w[d];
                cur_data[d]   <= wdata_w[d];
                cur_stable[d] <= 1'b1;
                cur_start[d]  <= cyc;
            end else if (!we_n_w[d]) begin
                cur_len[d] <= cur_len[d] + 1;
                if (addr_w[d] !== cur_addr[d] || wdata_w[d] !== cur_data[d]) cur_stable[d] <= 1'b0;
            end else if (prev_we[d] == 1'b0) begin
                mon_q.push_back('{cur_addr[d], cur_data[d], cur_len[d], cur_stable[d], cur_start[d], cyc});
            end
            if (req_w[d] && !prev_req[d]) begin
                req_rise_cyc[d] <= cyc;
                req_rises[d]    <= req_rises[d] + 1;
            end
            if (init_w[d] && !prev_init[d]) init_rise_cyc[d] <= cyc;
            prev_we[d]   <= we_n_w[d];
            prev_req[d]  <= req_w[d];
            prev_init[d] <= init_w[d];
        end
    end

    // Model: i-th byte of a word in the configured order.
    function automatic logic [7:0] model_byte(input logic [31:0] w, input int k, input bit msb);
        int sh;
        sh = msb ? 8 * (3 - k) : 8 * k;
        return 8'((w >> sh) & 32'hFF);
    endfunction

    // Model: address of the i-th stored byte.
    function automatic logic [AW-1:0] model_addr(input int base, input int i);
        return AW'((base + i) % (1 << AW));
    endfunction

    task automatic wait_writes(input int n, input int budget);
        int k;
        k = 0;
        while (mon_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (mon_q.size() < n) begin
            errors++;
            $display("FAIL wait_writes: got %0d write records, required %0d", mon_q.size(), n);
        end
    endtask

    task automatic send_word(input int d, input logic [31:0] w);
        int k;
        k = 0;
        @(negedge clk);
        while (req_w[d] !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (req_w[d] !== 1'b1) begin
            errors++;
            $display("FAIL send_word dut%0d: req=%b, required 1 within 200 cycles", d, req_w[d]);
        end
        word_s[d] = w;
        ack_s[d]  = 1'b1;
        @(negedge clk);
        ack_s[d]  = 1'b0;
        word_s[d] = $urandom;
    endtask

    task automatic do_host_reset(input int d);
        @(negedge clk);
        host_reset_s[d] = 1'b1;
        @(negedge clk);
        host_reset_s[d] = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_w[d] !== 1'b0 || addr_w[d] !== AW'(base_of[d]) || wdata_w[d] !== 8'h00 ||
                we_n_w[d] !== 1'b1 || init_w[d] !== 1'b0 || bytes_w[d] !== '0) begin
                errors++;
                $display("FAIL reset dut%0d: req=%b addr=%h data=%h we_n=%b init=%b bytes=%0d, required 0 %h 00 1 0 0",
                         d, req_w[d], addr_w[d], wdata_w[d], we_n_w[d], init_w[d], bytes_w[d], base_of[d]);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_w[d] !== 1'b1 || we_n_w[d] !== 1'b1) begin
                errors++;
                $display("FAIL start dut%0d: req=%b we_n=%b, required req=1 we_n=1", d, req_w[d], we_n_w[d]);
            end
        end
    endtask

    task automatic test_load_msb();
        logic [31:0] words [2];
        int b, r;
        words[0] = 32'h11223344;
        words[1] = 32'hAABBCCDD;
        b = mon_q.size();
        send_word(0, words[0]);
        send_word(0, words[1]);
        r = req_rise_cyc[0];
        wait_writes(b + LB_A, 300);
        repeat (3) @(negedge clk);
        for (int i = 0; i < LB_A; i++) begin
            checks++;
            if (b + i >= mon_q.size()) begin
                errors++;
                $display("FAIL msb_write[%0d]: missing, required %h:%h", i, model_addr(0, i), model_byte(words[i/4], i%4, 1'b1));
            end else if (mon_q[b+i].addr !== model_addr(0, i) || mon_q[b+i].data !== model_byte(words[i/4], i%4, 1'b1)) begin
                errors++;
                $display("FAIL msb_write[%0d]: got %h:%h, required %h:%h", i, mon_q[b+i].addr, mon_q[b+i].data,
                         model_addr(0, i), model_byte(words[i/4], i%4, 1'b1));
            end else if (mon_q[b+i].len != WP_A || !mon_q[b+i].stable) begin
                errors++;
                $display("FAIL msb_pulse[%0d]: len=%0d stable=%0d, required len=%0d stable=1", i, mon_q[b+i].len, mon_q[b+i].stable, WP_A);
            end
        end
        if (mon_q.size() >= b + LB_A) begin
            for (int i = 1; i < LB_A; i++) begin
                if (i % 4 != 0) begin
                    checks++;
                    if (mon_q[b+i].start_c - mon_q[b+i-1].start_c != 2 + WP_A) begin
                        errors++;
                        $display("FAIL byte_spacing[%0d]: got %0d cycles, required %0d", i,
                                 mon_q[b+i].start_c - mon_q[b+i-1].start_c, 2 + WP_A);
                    end
                end
            end
            checks++;
            if (r != mon_q[b+3].end_c + 1) begin
                errors++;
                $display("FAIL req_after_word: req rose at cycle %0d, required %0d", r, mon_q[b+3].end_c + 1);
            end
            checks++;
            if (init_rise_cyc[0] != mon_q[b+7].end_c + 1) begin
                errors++;
                $display("FAIL init_timing: init rose at cycle %0d, required %0d", init_rise_cyc[0], mon_q[b+7].end_c + 1);
            end
        end
        // An ack while DONE must be ignored.
        @(negedge clk);
        word_s[0] = 32'h99999999;
        ack_s[0]  = 1'b1;
        @(negedge clk);
        ack_s[0]  = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (mon_q.size() != b + LB_A || bytes_w[0] !== AW'(LB_A) || req_w[0] !== 1'b0 || init_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: writes=%0d bytes=%0d req=%b init=%b, required writes=%0d bytes=%0d req=0 init=1",
                     mon_q.size() - b, bytes_w[0], req_w[0], init_w[0], LB_A, LB_A);
        end
    endtask

    task automatic test_lsb();
        logic [31:0] w;
        int b;
        w = 32'h11223344;
        b = mon_q.size();
        send_word(1, w);
        wait_writes(b + LB_B, 200);
        repeat (3) @(negedge clk);
        for (int i = 0; i < LB_B; i++) begin
            checks++;
            if (b + i >= mon_q.size()) begin
                errors++;
                $display("FAIL lsb_write[%0d]: missing, required %h:%h", i, model_addr(0, i), model_byte(w, i, 1'b0));
            end else if (mon_q[b+i].addr !== model_addr(0, i) || mon_q[b+i].data !== model_byte(w, i, 1'b0) ||
                         mon_q[b+i].len != WP_B) begin
                errors++;
                $display("FAIL lsb_write[%0d]: got %h:%h len %0d, required %h:%h len %0d", i, mon_q[b+i].addr,
                         mon_q[b+i].data, mon_q[b+i].len, model_addr(0, i), model_byte(w, i, 1'b0), WP_B);
            end
        end
        checks++;
        if (init_w[1] !== 1'b1 || bytes_w[1] !== AW'(LB_B)) begin
            errors++;
            $display("FAIL lsb_done: init=%b bytes=%0d, required init=1 bytes=%0d", init_w[1], bytes_w[1], LB_B);
        end
    endtask

    task automatic test_partial();
        logic [31:0] words [2];
        int b, rises0;
        words[0] = 32'h01020304;
        words[1] = 32'h05060708;
        b = mon_q.size();
        rises0 = req_rises[2];
        send_word(2, words[0]);
        send_word(2, words[1]);
        wait_writes(b + LB_C, 200);
        repeat (20) @(negedge clk);
        checks++;
        if (mon_q.size() != b + LB_C) begin
            errors++;
            $display("FAIL partial_count: got %0d writes, required %0d", mon_q.size() - b, LB_C);
        end
        for (int i = 0; i < LB_C; i++) begin
            checks++;
            if (b + i >= mon_q.size()) begin
                errors++;
                $display("FAIL partial_write[%0d]: missing, required %h:%h", i, model_addr(BASEC, i), model_byte(words[i/4], i%4, 1'b1));
            end else if (mon_q[b+i].addr !== model_addr(BASEC, i) || mon_q[b+i].data !== model_byte(words[i/4], i%4, 1'b1) ||
                         mon_q[b+i].len != WP_C) begin
                errors++;
                $display("FAIL partial_write[%0d]: got %h:%h len %0d, required %h:%h len %0d", i, mon_q[b+i].addr,
                         mon_q[b+i].data, mon_q[b+i].len, model_addr(BASEC, i), model_byte(words[i/4], i%4, 1'b1), WP_C);
            end
        end
        checks++;
        if (bytes_w[2] !== AW'(LB_C) || init_w[2] !== 1'b1 || req_w[2] !== 1'b0 || req_rises[2] - rises0 != 1) begin
            errors++;
            $display("FAIL partial_done: bytes=%0d init=%b req=%b req_rises=%0d, required bytes=%0d init=1 req=0 req_rises=1",
                     bytes_w[2], init_w[2], req_w[2], req_rises[2] - rises0, LB_C);
        end
    endtask

    task automatic test_ack_held();
        int b, k;
        do_host_reset(0);
        b = mon_q.size();
        k = 0;
        @(negedge clk);
        while (req_w[0] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        word_s[0] = 32'h11223344;
        ack_s[0]  = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (mon_q.size() != b + 4 || req_w[0] !== 1'b1 || bytes_w[0] !== AW'(4)) begin
            errors++;
            $display("FAIL ack_held: writes=%0d req=%b bytes=%0d, required writes=4 req=1 bytes=4",
                     mon_q.size() - b, req_w[0], bytes_w[0]);
        end
        ack_s[0] = 1'b0;
        @(negedge clk);
        word_s[0] = 32'hAABBCCDD;
        ack_s[0]  = 1'b1;
        @(negedge clk);
        ack_s[0]  = 1'b0;
        wait_writes(b + 8, 200);
        repeat (3) @(negedge clk);
        for (int i = 4; i < 8; i++) begin
            checks++;
            if (b + i >= mon_q.size()) begin
                errors++;
                $display("FAIL ack_second[%0d]: missing", i);
            end else if (mon_q[b+i].addr !== model_addr(0, i) || mon_q[b+i].data !== model_byte(32'hAABBCCDD, i - 4, 1'b1)) begin
                errors++;
                $display("FAIL ack_second[%0d]: got %h:%h, required %h:%h", i, mon_q[b+i].addr, mon_q[b+i].data,
                         model_addr(0, i), model_byte(32'hAABBCCDD, i - 4, 1'b1));
            end
        end
    endtask

    task automatic test_host_reset();
        int b, k;
        do_host_reset(0);
        send_word(0, 32'h11223344);
        k = 0;
        while (!(we_n_w[0] === 1'b0 && addr_w[0] === AW'(1)) && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!(we_n_w[0] === 1'b0 && addr_w[0] === AW'(1))) begin
            errors++;
            $display("FAIL hr_find_pulse: we_n=%b addr=%h, required pulse on addr 1", we_n_w[0], addr_w[0]);
        end
        host_reset_s[0] = 1'b1;
        @(negedge clk);
        host_reset_s[0] = 1'b0;
        checks++;
        if (we_n_w[0] !== 1'b1 || addr_w[0] !== '0 || bytes_w[0] !== '0 || req_w[0] !== 1'b0 || init_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL hr_next: we_n=%b addr=%h bytes=%0d req=%b init=%b, required 1 0 0 0 0",
                     we_n_w[0], addr_w[0], bytes_w[0], req_w[0], init_w[0]);
        end
        @(negedge clk);
        checks++;
        if (req_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL hr_req: req=%b, required 1", req_w[0]);
        end
        @(posedge clk);
        b = mon_q.size();
        send_word(0, 32'h55667788);
        wait_writes(b + 4, 200);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b + i >= mon_q.size()) begin
                errors++;
                $display("FAIL hr_resend[%0d]: missing", i);
            end else if (mon_q[b+i].addr !== model_addr(0, i) || mon_q[b+i].data !== model_byte(32'h55667788, i, 1'b1)) begin
                errors++;
                $display("FAIL hr_resend[%0d]: got %h:%h, required %h:%h", i, mon_q[b+i].addr, mon_q[b+i].data,
                         model_addr(0, i), model_byte(32'h55667788, i, 1'b1));
            end
        end
        // host_reset and an ack edge in the same cycle: the word is dropped.
        k = 0;
        @(negedge clk);
        while (req_w[0] !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        host_reset_s[0] = 1'b1;
        word_s[0]       = 32'hDEADBEEF;
        ack_s[0]        = 1'b1;
        @(negedge clk);
        host_reset_s[0] = 1'b0;
        ack_s[0]        = 1'b0;
        @(posedge clk);
        b = mon_q.size();
        repeat (8) @(negedge clk);
        checks++;
        if (mon_q.size() != b || bytes_w[0] !== '0 || req_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL hr_with_ack: writes=%0d bytes=%0d req=%b, required writes=0 bytes=0 req=1",
                     mon_q.size() - b, bytes_w[0], req_w[0]);
        end
        send_word(0, 32'h0BADF00D);
        wait_writes(b + 1, 100);
        checks++;
        if (mon_q.size() <= b || mon_q[b].addr !== '0 || mon_q[b].data !== 8'h0B) begin
            errors++;
            $display("FAIL hr_after_drop: first write missing or wrong, required 000000:0b");
        end
    endtask

    task automatic test_random();
        logic [31:0] words [2];
        int b;
        for (int it = 0; it < 3; it++) begin
            do_host_reset(0);
            b = mon_q.size();
            words[0] = $urandom;
            words[1] = $urandom;
            send_word(0, words[0]);
            send_word(0, words[1]);
            wait_writes(b + LB_A, 300);
            repeat (3) @(negedge clk);
            for (int i = 0; i < LB_A; i++) begin
                checks++;
                if (b + i >= mon_q.size()) begin
                    errors++;
                    $display("FAIL rand%0d_write[%0d]: missing", it, i);
                end else if (mon_q[b+i].addr !== model_addr(0, i) || mon_q[b+i].data !== model_byte(words[i/4], i%4, 1'b1) ||
                             mon_q[b+i].len != WP_A) begin
                    errors++;
                    $display("FAIL rand%0d_write[%0d]: got %h:%h len %0d, required %h:%h len %0d", it, i, mon_q[b+i].addr,
                             mon_q[b+i].data, mon_q[b+i].len, model_addr(0, i), model_byte(words[i/4], i%4, 1'b1), WP_A);
                end
            end
            checks++;
            if (init_w[0] !== 1'b1 || bytes_w[0] !== AW'(LB_A)) begin
                errors++;
                $display("FAIL rand%0d_done: init=%b bytes=%0d, required init=1 bytes=%0d", it, init_w[0], bytes_w[0], LB_A);
            end
        end
    endtask

    task automatic test_reset_n_done();
        int k;
        @(negedge clk);
        checks++;
        if (init_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstn_pre: init=%b, required 1", init_w[0]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (req_w[0] !== 1'b0 || addr_w[0] !== '0 || wdata_w[0] !== 8'h00 || we_n_w[0] !== 1'b1 ||
            init_w[0] !== 1'b0 || bytes_w[0] !== '0 || addr_w[2] !== AW'(BASEC)) begin
            errors++;
            $display("FAIL rstn_async: req=%b addr=%h data=%h we_n=%b init=%b bytes=%0d addr_c=%h, required 0 0 00 1 0 0 %h",
                     req_w[0], addr_w[0], wdata_w[0], we_n_w[0], init_w[0], bytes_w[0], addr_w[2], BASEC);
        end
        @(negedge clk);
        reset_n = 1'b1;
        k = 0;
        while (req_w[0] !== 1'b1 && k < 2) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (req_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstn_release: req=%b after 2 cycles, required 1", req_w[0]);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            host_reset_s[d] = 1'b0;
            ack_s[d]        = 1'b0;
            word_s[d]       = '0;
        end
        test_reset();
        test_load_msb();
        test_lsb();
        test_partial();
        test_ack_held();
        test_host_reset();
        test_random();
        test_reset_n_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
